// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit defaults, arbiter state encoding, statistics counter width.
package noc_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int PKT_CNT_W  = 16;

  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request found searching ptr+1, ptr+2, ... modulo N.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt_onehot,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  // Scan from the slot after the last winner, wrapping at N-1.
  always_comb begin : pick_blk
    logic [IW-1:0] idx_s;
    gnt_onehot = '0;
    gnt_idx    = '0;
    any        = 1'b0;
    idx_s      = '0;
    for (int off = 1; off <= N; off++) begin
      idx_s = IW'((int'(ptr) + off) % N);
      if (!any && req[idx_s]) begin
        any               = 1'b1;
        gnt_onehot[idx_s] = 1'b1;
        gnt_idx           = idx_s;
      end else begin
        any = any;
      end
    end
  end

endmodule

// File: rtl/vc_switch_arbiter.sv
// Wormhole VC-to-output-port arbiter with registered valid/ready output stage.
// Optional per-VC packet counters are built when VC_ARB_STATS_EN is defined.
module vc_switch_arbiter
  import noc_pkg::*;
#(
  parameter int NUM_VC   = 4,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int VC_IDX_W = $clog2(NUM_VC)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_VC*DATA_W-1:0] vc_data,
  input  logic [NUM_VC-1:0]        vc_valid,
  input  logic [NUM_VC-1:0]        vc_head,
  input  logic [NUM_VC-1:0]        vc_tail,
  output logic [NUM_VC-1:0]        vc_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic                     out_valid,
  output logic                     out_head,
  output logic                     out_tail,
  input  logic                     out_ready,
  output logic [VC_IDX_W-1:0]      grant_vc,
  output logic                     grant_locked
`ifdef VC_ARB_STATS_EN
  ,
  output logic [NUM_VC*PKT_CNT_W-1:0] pkt_count
`endif
);

  arb_state_e            state_r;
  logic [VC_IDX_W-1:0]   rr_ptr_r;
  logic                  can_accept_s;
  logic [NUM_VC-1:0]     cand_s;
  logic [NUM_VC-1:0]     win_oh_s;
  logic [VC_IDX_W-1:0]   win_idx_s;
  logic                  win_any_s;
  logic [VC_IDX_W-1:0]   sel_idx_s;
  logic                  xfer_s;
  logic [DATA_W-1:0]     sel_data_s;
  logic                  sel_head_s;
  logic                  sel_tail_s;

  assign can_accept_s = !out_valid || out_ready;
  assign cand_s       = vc_valid & vc_head;

  rr_arbiter #(
    .N  (NUM_VC),
    .IW (VC_IDX_W)
  ) u_rr (
    .req        (cand_s),
    .ptr        (rr_ptr_r),
    .gnt_onehot (win_oh_s),
    .gnt_idx    (win_idx_s),
    .any        (win_any_s)
  );

  // Ready steering: the locked VC owns the port; otherwise only the head-flit winner may enter.
  always_comb begin
    vc_ready  = '0;
    sel_idx_s = win_idx_s;
    case (state_r)
      ARB_LOCKED: begin
        sel_idx_s          = grant_vc;
        vc_ready[grant_vc] = can_accept_s;
      end
      ARB_IDLE: begin
        if (win_any_s) begin
          vc_ready = win_oh_s & {NUM_VC{can_accept_s}};
        end else begin
          vc_ready = '0;
        end
      end
      default: begin
        vc_ready = '0;
      end
    endcase
  end

  assign xfer_s     = |(vc_valid & vc_ready);
  assign sel_data_s = vc_data[int'(sel_idx_s)*DATA_W +: DATA_W];
  assign sel_head_s = vc_head[sel_idx_s];
  assign sel_tail_s = vc_tail[sel_idx_s];

  // Lock/round-robin state: lock on head-only, release on tail; pointer records the last packet owner.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= ARB_IDLE;
      rr_ptr_r     <= VC_IDX_W'(NUM_VC - 1);
      grant_vc     <= '0;
      grant_locked <= 1'b0;
    end else begin
      case (state_r)
        ARB_IDLE: begin
          if (xfer_s && sel_tail_s) begin
            rr_ptr_r <= sel_idx_s;
          end else if (xfer_s) begin
            state_r      <= ARB_LOCKED;
            grant_vc     <= sel_idx_s;
            grant_locked <= 1'b1;
          end
        end
        ARB_LOCKED: begin
          if (xfer_s && sel_tail_s) begin
            state_r      <= ARB_IDLE;
            rr_ptr_r     <= grant_vc;
            grant_locked <= 1'b0;
          end
        end
        default: begin
          state_r      <= ARB_IDLE;
          grant_locked <= 1'b0;
        end
      endcase
    end
  end

  // Output register: load on transfer, otherwise drain valid when downstream takes the flit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      out_head  <= 1'b0;
      out_tail  <= 1'b0;
    end else if (xfer_s) begin
      out_data  <= sel_data_s;
      out_valid <= 1'b1;
      out_head  <= sel_head_s;
      out_tail  <= sel_tail_s;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef VC_ARB_STATS_EN
  // Per-VC packet counters, bumped on each tail transfer and wrapping naturally.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_count <= '0;
    end else if (xfer_s && sel_tail_s) begin
      pkt_count[int'(sel_idx_s)*PKT_CNT_W +: PKT_CNT_W] <=
        pkt_count[int'(sel_idx_s)*PKT_CNT_W +: PKT_CNT_W] + PKT_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_vc_switch_arbiter.sv
// Directed vector bench for vc_switch_arbiter (4 VCs, 32-bit flits).
module tb_vc_switch_arbiter;

  localparam int NUM_VC = 4;
  localparam int DATA_W = 32;
  localparam int NV     = 20;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic [NUM_VC*DATA_W-1:0] vc_data;
  logic [NUM_VC-1:0]        vc_valid, vc_head, vc_tail, vc_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid, out_head, out_tail, out_ready;
  logic [1:0]               grant_vc;
  logic                     grant_locked;
`ifdef VC_ARB_STATS_EN
  logic [NUM_VC*16-1:0]     pkt_count;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  vc_switch_arbiter #(.NUM_VC(NUM_VC), .DATA_W(DATA_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .vc_data      (vc_data),
    .vc_valid     (vc_valid),
    .vc_head      (vc_head),
    .vc_tail      (vc_tail),
    .vc_ready     (vc_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_head     (out_head),
    .out_tail     (out_tail),
    .out_ready    (out_ready),
    .grant_vc     (grant_vc),
    .grant_locked (grant_locked)
`ifdef VC_ARB_STATS_EN
    ,
    .pkt_count    (pkt_count)
`endif
  );

  typedef struct {
    logic [3:0]   valid, head, tail;
    logic         ordy;
    logic [127:0] data;
    logic [3:0]   rdy;
    logic         ov;
    logic [31:0]  od;
    logic         oh, ot, lk;
    logic [1:0]   gv;
  } vec_t;

  vec_t vecs[NV];

  function automatic vec_t mk(input logic [3:0] valid, head, tail, input logic ordy,
                              input logic [31:0] d3, d2, d1, d0, input logic [3:0] rdy,
                              input logic ov, input logic [31:0] od,
                              input logic oh, ot, lk, input logic [1:0] gv);
    vec_t v;
    v.valid = valid; v.head = head; v.tail = tail; v.ordy = ordy;
    v.data  = {d3, d2, d1, d0};
    v.rdy   = rdy; v.ov = ov; v.od = od; v.oh = oh; v.ot = ot; v.lk = lk; v.gv = gv;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    // Wormhole packet on VC0
    vecs[0]  = mk(4'b0001, 4'b0001, 4'b0000, 1'b1, 0, 0, 0, 32'hA0, 4'b0001, 1'b1, 32'hA0, 1'b1, 1'b0, 1'b1, 2'd0);
    vecs[1]  = mk(4'b0001, 4'b0000, 4'b0000, 1'b1, 0, 0, 0, 32'hA1, 4'b0001, 1'b1, 32'hA1, 1'b0, 1'b0, 1'b1, 2'd0);
    vecs[2]  = mk(4'b0001, 4'b0000, 4'b0001, 1'b1, 0, 0, 0, 32'hA2, 4'b0001, 1'b1, 32'hA2, 1'b0, 1'b1, 1'b0, 2'd0);
    vecs[3]  = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 0, 0, 0,      4'b0000, 1'b0, 32'hA2, 1'b0, 1'b1, 1'b0, 2'd0);
    // VC1/VC2 single-flit packets alternate
    vecs[4]  = mk(4'b0110, 4'b0110, 4'b0110, 1'b1, 0, 32'hC2, 32'hB1, 0, 4'b0010, 1'b1, 32'hB1, 1'b1, 1'b1, 1'b0, 2'd0);
    vecs[5]  = mk(4'b0110, 4'b0110, 4'b0110, 1'b1, 0, 32'hC2, 32'hB1, 0, 4'b0100, 1'b1, 32'hC2, 1'b1, 1'b1, 1'b0, 2'd0);
    vecs[6]  = mk(4'b0110, 4'b0110, 4'b0110, 1'b1, 0, 32'hC2, 32'hB1, 0, 4'b0010, 1'b1, 32'hB1, 1'b1, 1'b1, 1'b0, 2'd0);
    vecs[7]  = mk(4'b0110, 4'b0110, 4'b0110, 1'b1, 0, 32'hC2, 32'hB1, 0, 4'b0100, 1'b1, 32'hC2, 1'b1, 1'b1, 1'b0, 2'd0);
    // VC3 locked, stalls, VC0 head blocked until tail
    vecs[8]  = mk(4'b1001, 4'b1001, 4'b0000, 1'b1, 32'hD0, 0, 0, 32'hE0, 4'b1000, 1'b1, 32'hD0, 1'b1, 1'b0, 1'b1, 2'd3);
    vecs[9]  = mk(4'b0001, 4'b0001, 4'b0000, 1'b1, 0,      0, 0, 32'hE0, 4'b1000, 1'b0, 32'hD0, 1'b1, 1'b0, 1'b1, 2'd3);
    vecs[10] = mk(4'b1001, 4'b0001, 4'b1000, 1'b1, 32'hD1, 0, 0, 32'hE0, 4'b1000, 1'b1, 32'hD1, 1'b0, 1'b1, 1'b0, 2'd3);
    vecs[11] = mk(4'b0001, 4'b0001, 4'b0001, 1'b1, 0,      0, 0, 32'hE0, 4'b0001, 1'b1, 32'hE0, 1'b1, 1'b1, 1'b0, 2'd3);
    // Backpressure for three cycles on a VC1 packet
    vecs[12] = mk(4'b0010, 4'b0010, 4'b0000, 1'b1, 0, 0, 32'hF0, 0, 4'b0010, 1'b1, 32'hF0, 1'b1, 1'b0, 1'b1, 2'd1);
    vecs[13] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 0, 0, 32'hF1, 0, 4'b0000, 1'b1, 32'hF0, 1'b1, 1'b0, 1'b1, 2'd1);
    vecs[14] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 0, 0, 32'hF1, 0, 4'b0000, 1'b1, 32'hF0, 1'b1, 1'b0, 1'b1, 2'd1);
    vecs[15] = mk(4'b0010, 4'b0000, 4'b0000, 1'b0, 0, 0, 32'hF1, 0, 4'b0000, 1'b1, 32'hF0, 1'b1, 1'b0, 1'b1, 2'd1);
    vecs[16] = mk(4'b0010, 4'b0000, 4'b0000, 1'b1, 0, 0, 32'hF1, 0, 4'b0010, 1'b1, 32'hF1, 1'b0, 1'b0, 1'b1, 2'd1);
    vecs[17] = mk(4'b0010, 4'b0000, 4'b0010, 1'b1, 0, 0, 32'hF2, 0, 4'b0010, 1'b1, 32'hF2, 1'b0, 1'b1, 1'b0, 2'd1);
    vecs[18] = mk(4'b0000, 4'b0000, 4'b0000, 1'b1, 0, 0, 0,      0, 4'b0000, 1'b0, 32'hF2, 1'b0, 1'b1, 1'b0, 2'd1);
    // Body flit without a lock is never accepted in IDLE
    vecs[19] = mk(4'b0100, 4'b0000, 4'b0000, 1'b1, 0, 32'h77, 0, 0, 4'b0000, 1'b0, 32'hF2, 1'b0, 1'b1, 1'b0, 2'd1);

    reset_n   = 1'b0;
    vc_data   = '0;
    vc_valid  = '0;
    vc_head   = '0;
    vc_tail   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outs", {out_valid, out_data, out_head, out_tail, grant_locked, grant_vc}, 64'd0);
    chk("reset_ready", vc_ready, 64'd0);
`ifdef VC_ARB_STATS_EN
    chk("reset_stats", pkt_count, 64'd0);
`endif
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      vc_valid  = vecs[i].valid;
      vc_head   = vecs[i].head;
      vc_tail   = vecs[i].tail;
      vc_data   = vecs[i].data;
      out_ready = vecs[i].ordy;
      #1;
      chk($sformatf("v%0d_ready", i), vc_ready, vecs[i].rdy);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out", i), {out_valid, out_data, out_head, out_tail, grant_locked, grant_vc},
          {vecs[i].ov, vecs[i].od, vecs[i].oh, vecs[i].ot, vecs[i].lk, vecs[i].gv});
    end

`ifdef VC_ARB_STATS_EN
    chk("stats_counts", pkt_count, {16'd1, 16'd2, 16'd3, 16'd2});
`endif

    // Lock VC2 mid-packet, then hit reset asynchronously between edges
    @(negedge clk);
    vc_valid  = 4'b0100;
    vc_head   = 4'b0100;
    vc_tail   = 4'b0000;
    vc_data   = {32'h0, 32'hC7, 32'h0, 32'h0};
    out_ready = 1'b1;
    #1;
    chk("rst_seq_ready", vc_ready, 64'b0100);
    @(posedge clk);
    #1;
    chk("rst_seq_lock", {out_valid, out_data, grant_locked, grant_vc}, {1'b1, 32'hC7, 1'b1, 2'd2});
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_rst_outs", {out_valid, grant_locked, out_data}, 64'd0);
`ifdef VC_ARB_STATS_EN
    chk("async_rst_stats", pkt_count, 64'd0);
`endif
    @(posedge clk);
    @(negedge clk);
    reset_n  = 1'b1;
    vc_valid = 4'b0101;
    vc_head  = 4'b0101;
    vc_data  = {32'h0, 32'hC8, 32'h0, 32'h11};
    #1;
    chk("post_rst_ready", vc_ready, 64'b0001);
    @(posedge clk);
    #1;
    chk("post_rst_out", {out_valid, out_data, grant_locked, grant_vc}, {1'b1, 32'h11, 1'b1, 2'd0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_switch_arbiter.md
Name: vc_switch_arbiter

Overview:
- Shares one router output port between NUM_VC virtual-channel buffers.
- Uses round-robin selection among head flits, then locks the grant from head flit to tail flit (wormhole).
- Drives a registered output stage with a valid/ready handshake toward the downstream router.
- Sits between the per-port VC buffers and the crossbar/link stage.

Parameters:
- NUM_VC, 4, number of virtual-channel requesters (2..8)
- DATA_W, 32, flit payload width
- VC_IDX_W, $clog2(NUM_VC), width of the grant index (derived, not overridden)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- vc_data  in  NUM_VC*DATA_W  flattened flits; VC i occupies bits [i*DATA_W +: DATA_W]
- vc_valid  in  NUM_VC  per-VC flit valid
- vc_head  in  NUM_VC  per-VC head-flit marker
- vc_tail  in  NUM_VC  per-VC tail-flit marker
- vc_ready  out  NUM_VC  per-VC accept (combinational)
- out_data  out  DATA_W  registered outgoing flit
- out_valid  out  1  registered outgoing valid
- out_head  out  1  registered head marker
- out_tail  out  1  registered tail marker
- out_ready  in  1  downstream ready
- grant_vc  out  VC_IDX_W  currently locked VC index
- grant_locked  out  1  high while a packet is in flight (state LOCKED)

Behaviour:
- Clock and reset: single clock clk; reset_n is asynchronous and active-low.
- Reset values:
  - out_data=0, out_valid=0, out_head=0, out_tail=0.
  - grant_vc=0, grant_locked=0, state=IDLE.
  - rr_ptr=NUM_VC-1, so VC0 has top priority after reset.
- Output acceptance: can_accept = !out_valid || out_ready. A flit transfers from VC i when vc_valid[i] && vc_ready[i]. At most one vc_ready bit is high per cycle.
- Latency: an accepted flit appears on out_* the next cycle. If out_ready stays high, throughput is 1 flit/cycle.
- Output register update:
  - On a transfer, load out_data/head/tail from the VC and set out_valid=1.
  - Else, if out_valid && out_ready, clear out_valid. out_data/head/tail hold their values.
- State IDLE:
  - Candidates are VCs with vc_valid && vc_head.
  - Winner is the first candidate found searching rr_ptr+1, rr_ptr+2, ... modulo NUM_VC.
  - vc_ready[winner] = can_accept; all other vc_ready bits are 0.
  - On transfer of a head without tail: go to LOCKED, set grant_vc=winner and grant_locked=1.
  - On transfer of a head+tail (single-flit packet): stay IDLE, set rr_ptr=winner.
  - Non-head valid flits in IDLE are never accepted; they stall with vc_ready=0.
  - If there are no candidates, vc_ready=0.
- State LOCKED:
  - vc_ready[grant_vc] = can_accept; all other vc_ready bits are 0.
  - Flits from grant_vc pass through regardless of head marker.
  - On tail transfer: go to IDLE, set rr_ptr=grant_vc, grant_locked=0.
  - Other VCs are blocked until the tail transfers, even if grant_vc stalls (vc_valid low).
- Backpressure: when out_valid && !out_ready, all vc_ready=0 and the output register holds.
- Simultaneous events:
  - The output drain and a new load in the same cycle give a back-to-back flit; out_valid stays 1.
  - A tail transfer and a new arbitration never happen in the same cycle. The next head is arbitrated in the cycle after the tail (1-cycle bubble only in IDLE entry).
- Reset mid-packet: the lock is dropped and out_valid cleared. Partially forwarded packets are lost; upstream flushing is the system's responsibility.
- rr_ptr wrap: after index NUM_VC-1 the search continues at 0.

Optional Feature:
- Macro: VC_ARB_STATS_EN.
- Defined:
  - Adds output pkt_count[NUM_VC*16-1:0], one 16-bit counter per VC.
  - A VC's counter increments on every tail-flit transfer from that VC and wraps 0xFFFF->0.
  - Counters reset to 0.
- Undefined: no counters and no pkt_count port. Core behaviour is identical.

Decomposition:
- Shared package noc_pkg holds:
  - flit field constants: DATA_W default, HEAD/TAIL bit positions if encoded.
  - arbiter state encoding: ARB_IDLE=1'b0, ARB_LOCKED=1'b1.
  - the pkt-count width constant (16).
- One natural sub-module, rr_arbiter: a combinational round-robin picker with inputs req[NUM_VC] and ptr, and outputs gnt_onehot and gnt_idx plus any. It is reused by other allocators.
- State, lock and output register stay in vc_switch_arbiter.

Test Plan:
- Reset release, out_ready=1; VC0 sends head, body, tail (data 0xA0,0xA1,0xA2) -> out_data 0xA0,0xA1,0xA2 on consecutive cycles starting 1 cycle after the head accept; grant_locked high from the cycle after the head to the cycle after the tail.
- VC1 and VC2 both present single-flit packets (head+tail, 0xB1 and 0xC2) continuously from reset -> order VC0? none, so VC1 then VC2 then VC1 ...; rr_ptr alternates and no VC is served twice in a row.
- VC3 locked mid-packet while VC0 presents a head -> VC0 vc_ready stays 0 until the VC3 tail transfers; VC0 head is granted the cycle after.
- out_ready held 0 for 3 cycles with out_valid=1 -> all vc_ready=0; out_data is stable for 3 cycles; flow resumes with no loss or duplication.
- reset_n asserted asynchronously mid-packet on VC2 -> out_valid=0 and grant_locked=0 immediately; after release, VC0 wins the first arbitration.
- With VC_ARB_STATS_EN defined: 3 packets on VC1 and 1 on VC2 -> pkt_count[31:16]=3, pkt_count[47:32]=1, others 0.
